// File: rtl/iir_hpf_pkg.sv
// Shared types and constants for the first-order IIR high-pass stage.
package iir_hpf_pkg;

  typedef enum logic [1:0] {
    GET = 2'd0,
    MUL = 2'd1,
    ADD = 2'd2,
    PUT = 2'd3
  } state_e;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned COEF_W_DEF    = 16;
  localparam int unsigned COEF_FRAC_DEF = 15;
  localparam int          COEF_A_DEF    = 32440;

  // Half an LSB of the feedback product; adding it before the shift rounds half toward +inf.
  function automatic longint rnd_ofs(input int unsigned frac);
    return (frac == 0) ? 64'sd0 : (64'sd1 <<< (frac - 1));
  endfunction

  function automatic longint sat_hi(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Reduces the DATA_W+2 bit accumulator to DATA_W bits.
// IIR_HPF_SAT_EN selects saturation; otherwise two's-complement wrap.
module fxp_round_sat
  import iir_hpf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W+1:0] sum_i,
  output logic signed [DATA_W-1:0] z_c_o
);

`ifdef IIR_HPF_SAT_EN
  localparam logic signed [DATA_W+1:0] SAT_HI = (DATA_W+2)'(sat_hi(DATA_W));
  localparam logic signed [DATA_W+1:0] SAT_LO = (DATA_W+2)'(sat_lo(DATA_W));

  always_comb begin
    z_c_o = DATA_W'(sum_i);
    if (sum_i > SAT_HI) begin
      z_c_o = DATA_W'(SAT_HI);
    end else if (sum_i < SAT_LO) begin
      z_c_o = DATA_W'(SAT_LO);
    end
  end
`else
  assign z_c_o = DATA_W'(sum_i);
`endif

endmodule

// File: rtl/iir_hpf_stage.sv
// First-order DC-blocking IIR: y[n] = x[n] - x[n-1] + a*y[n-1], stb/ack in and out.
// Define IIR_HPF_SAT_EN to saturate the output instead of wrapping.
module iir_hpf_stage
  import iir_hpf_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned COEF_W    = COEF_W_DEF,
  parameter int unsigned COEF_FRAC = COEF_FRAC_DEF,
  parameter int          COEF_A    = COEF_A_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] input_a,
  input  logic              input_a_stb,
  output logic              input_a_ack,
  output logic [DATA_W-1:0] output_z,
  output logic              output_z_stb,
  input  logic              output_z_ack
);

  localparam int unsigned DW1 = DATA_W + 1;
  localparam int unsigned SW  = DATA_W + 2;
  localparam int unsigned PW  = DATA_W + COEF_W;

  localparam logic signed [PW-1:0] COEF = PW'(COEF_W'(COEF_A));
  localparam logic signed [PW-1:0] RND  = PW'(rnd_ofs(COEF_FRAC));

  state_e state_q, state_d;
  logic   ack_q, ack_d;
  logic   stb_q, stb_d;

  logic signed [DATA_W-1:0] x_cur_q, x_cur_d;
  logic signed [DATA_W-1:0] x_prev_q, x_prev_d;
  logic signed [DATA_W-1:0] y_prev_q, y_prev_d;
  logic signed [DATA_W-1:0] z_q, z_d;
  logic signed [DW1-1:0]    diff_q, diff_d;
  logic signed [PW-1:0]     prod_q, prod_d;

  logic signed [SW-1:0]     fb_c;
  logic signed [SW-1:0]     sum_c;
  logic signed [DATA_W-1:0] red_c;

  // Rounded feedback term plus difference, one guard bit each side.
  always_comb begin
    fb_c  = SW'((prod_q + RND) >>> COEF_FRAC);
    sum_c = SW'(diff_q) + fb_c;
  end

  fxp_round_sat #(
    .DATA_W(DATA_W)
  ) u_round_sat (
    .sum_i(sum_c),
    .z_c_o(red_c)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    stb_d    = stb_q;
    x_cur_d  = x_cur_q;
    x_prev_d = x_prev_q;
    y_prev_d = y_prev_q;
    z_d      = z_q;
    diff_d   = diff_q;
    prod_d   = prod_q;

    case (state_q)
      GET: begin
        if (ack_q) begin
          if (input_a_stb) begin
            x_cur_d = input_a;
            state_d = MUL;
          end
        end else begin
          ack_d = input_a_stb;
        end
      end
      MUL: begin
        diff_d  = DW1'(x_cur_q) - DW1'(x_prev_q);
        prod_d  = COEF * PW'(y_prev_q);
        state_d = ADD;
      end
      ADD: begin
        z_d      = red_c;
        stb_d    = 1'b1;
        x_prev_d = x_cur_q;
        y_prev_d = red_c;
        state_d  = PUT;
      end
      PUT: begin
        // Pre-arm ack on the way back to GET so a held stb sustains 1 sample per 4 clocks.
        if (output_z_ack) begin
          stb_d   = 1'b0;
          ack_d   = input_a_stb;
          state_d = GET;
        end
      end
      default: state_d = GET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GET;
      ack_q    <= 1'b0;
      stb_q    <= 1'b0;
      x_cur_q  <= '0;
      x_prev_q <= '0;
      y_prev_q <= '0;
      z_q      <= '0;
      diff_q   <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      stb_q    <= stb_d;
      x_cur_q  <= x_cur_d;
      x_prev_q <= x_prev_d;
      y_prev_q <= y_prev_d;
      z_q      <= z_d;
      diff_q   <= diff_d;
      prod_q   <= prod_d;
    end
  end

  assign input_a_ack  = ack_q;
  assign output_z     = z_q;
  assign output_z_stb = stb_q;

endmodule

// File: tb/tb_iir_hpf_stage.sv
// Directed bench: instance A uses a=0.5 (16384), instance B uses a=0, both in lockstep.
module tb_iir_hpf_stage;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] input_a = '0;
  logic               input_a_stb = 1'b0;
  logic               output_z_ack = 1'b1;

  logic               ack_a, stb_a, ack_b, stb_b;
  logic signed [31:0] z_a, z_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iir_hpf_stage #(.COEF_A(16384)) u_dut_a (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(ack_a),
    .output_z(z_a), .output_z_stb(stb_a), .output_z_ack(output_z_ack)
  );

  iir_hpf_stage #(.COEF_A(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(ack_b),
    .output_z(z_b), .output_z_stb(stb_b), .output_z_ack(output_z_ack)
  );

  typedef struct {
    bit                 rst_first;
    logic signed [31:0] x;
    logic signed [31:0] exp_a;
    logic signed [31:0] exp_b;
  } vec_t;

  localparam logic signed [31:0] MIN32 = 32'sh8000_0000;
  localparam logic signed [31:0] MAX32 = 32'sh7FFF_FFFF;
`ifdef IIR_HPF_SAT_EN
  localparam logic signed [31:0] OVF_A = MAX32;
  localparam logic signed [31:0] OVF_B = MAX32;
`else
  localparam logic signed [31:0] OVF_A = 32'shBFFF_FFFF;
  localparam logic signed [31:0] OVF_B = -32'sd1;
`endif

  vec_t vecs[13];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out, got no handshake, expected one within 20 cycles", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    input_a_stb = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Present x, wait for the accept edge, then count clocks until output_z_stb rises.
  task automatic send(input logic signed [31:0] x, output int lat, output logic signed [31:0] za,
                      output logic signed [31:0] zb);
    int n;
    input_a     = x;
    input_a_stb = 1'b1;
    n = 0;
    while (!ack_a && n < 20) begin
      tick();
      n++;
    end
    if (!ack_a) timeout("accept");
    tick();
    input_a_stb = 1'b0;
    lat = 1;
    while (!stb_a && lat < 20) begin
      tick();
      lat++;
    end
    if (!stb_a) timeout("output_stb");
    za = z_a;
    zb = z_b;
  endtask

  initial begin
    int                 lat;
    logic signed [31:0] za, zb;
    int                 seen;

    vecs[0]  = '{1'b0, 32'sd1000, 32'sd1000, 32'sd1000};
    vecs[1]  = '{1'b0, 32'sd1000, 32'sd500,  32'sd0};
    vecs[2]  = '{1'b0, 32'sd1000, 32'sd250,  32'sd0};
    vecs[3]  = '{1'b0, 32'sd1000, 32'sd125,  32'sd0};
    vecs[4]  = '{1'b0, 32'sd1000, 32'sd63,   32'sd0};
    vecs[5]  = '{1'b1, -32'sd1000, -32'sd1000, -32'sd1000};
    vecs[6]  = '{1'b0, -32'sd1000, -32'sd500,  32'sd0};
    vecs[7]  = '{1'b0, -32'sd1000, -32'sd250,  32'sd0};
    vecs[8]  = '{1'b0, -32'sd1000, -32'sd125,  32'sd0};
    vecs[9]  = '{1'b0, -32'sd1000, -32'sd62,   32'sd0};
    vecs[10] = '{1'b1, MIN32, MIN32, MIN32};
    vecs[11] = '{1'b0, MAX32, OVF_A, OVF_B};
    vecs[12] = '{1'b1, 32'sd2000, 32'sd2000, 32'sd2000};

    // Reset held with stb high: nothing may be acknowledged or emitted.
    rst         = 1'b1;
    input_a     = 32'sd1000;
    input_a_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ack", ack_a, 1'b0);
      chk("rst_stb", stb_a, 1'b0);
      chk("rst_z", z_a, 32'sd0);
    end
    rst = 1'b0;
    tick();
    chk("first_ack_after_rst", ack_a, 1'b1);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst_first) do_reset();
      send(vecs[i].x, lat, za, zb);
      chk($sformatf("vec%0d_z_a", i), za, vecs[i].exp_a);
      chk($sformatf("vec%0d_z_b", i), zb, vecs[i].exp_b);
      chk($sformatf("vec%0d_latency", i), lat, 3);
    end

    // Backpressure: output held, no input accepted while downstream stalls.
    do_reset();
    output_z_ack = 1'b0;
    send(vecs[12].x, lat, za, zb);
    chk("bp_first_z_a", za, vecs[12].exp_a);
    chk("bp_first_z_b", zb, vecs[12].exp_b);
    input_a     = 32'sd3000;
    input_a_stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stb_held", stb_a, 1'b1);
      chk("bp_z_held", z_a, 32'sd2000);
      chk("bp_no_ack", ack_a, 1'b0);
    end
    output_z_ack = 1'b1;
    tick();
    chk("bp_stb_drop", stb_a, 1'b0);
    chk("bp_z_keep", z_a, 32'sd2000);
    chk("bp_next_ack", ack_a, 1'b1);
    send(32'sd3000, lat, za, zb);
    chk("bp_second_z_a", za, 32'sd2000);
    chk("bp_second_z_b", zb, 32'sd1000);
    chk("bp_second_latency", lat, 3);

    // Reset while the 500 sample sits in ADD: it must vanish and history must clear.
    input_a     = 32'sd500;
    input_a_stb = 1'b1;
    seen = 0;
    while (!ack_a && seen < 20) begin
      tick();
      seen++;
    end
    if (!ack_a) timeout("midrst_accept");
    tick();
    input_a_stb = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_z", z_a, 32'sd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (stb_a) seen++;
      tick();
    end
    chk("midrst_no_stb", seen, 0);
    send(32'sd700, lat, za, zb);
    chk("midrst_z_a", za, 32'sd700);
    chk("midrst_z_b", zb, 32'sd700);
    chk("midrst_latency", lat, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
